// File: rtl/core_bus_arbiter_pkg.sv
// Shared types and constants for core_bus_arbiter: FSM states, the latched
// memory request record and the fixed fetch size.
package core_bus_arbiter_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;

  // Fetches are always single 32-bit words (log2 bytes = 2).
  localparam logic [2:0] MSIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ARB_ADDR_W-1:0] addr;
    logic [2:0]            size;
    logic [7:0]            strobe;
    logic [ARB_DATA_W-1:0] data;
  } mreq_t;

endpackage

// File: rtl/core_bus_arbiter_req_latch.sv
// Request holding register: captures the granted master's request so the
// memory side sees stable fields for the whole transaction.
module arb_req_latch
  import core_bus_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  mreq_t d,
  output mreq_t q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges the core's fetch and data buses onto one single-beat memory channel.
// Optional macro ARB_ROUND_ROBIN_EN alternates priority when both masters wait.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ireq_valid,
  input  logic [ADDR_W-1:0] ireq_addr,
  output logic              iresp_addr_ok,
  output logic              iresp_data_ok,
  output logic [31:0]       iresp_data,
  input  logic              dreq_valid,
  input  logic [ADDR_W-1:0] dreq_addr,
  input  logic [2:0]        dreq_size,
  input  logic [7:0]        dreq_strobe,
  input  logic [DATA_W-1:0] dreq_data,
  output logic              dresp_addr_ok,
  output logic              dresp_data_ok,
  output logic [DATA_W-1:0] dresp_data,
  output logic              mreq_valid,
  output logic              mreq_write,
  output logic [ADDR_W-1:0] mreq_addr,
  output logic [2:0]        mreq_size,
  output logic [7:0]        mreq_strobe,
  output logic [DATA_W-1:0] mreq_data,
  input  logic              mresp_ok,
  input  logic [DATA_W-1:0] mresp_data
);

  arb_state_e state;
  logic       grant_d;
  logic       grant_i;
  mreq_t      req_next;
  mreq_t      req_q;
  logic       complete;
  logic       i_done;
  logic       d_done;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted last, so fetch wins the next tie; reset favours data.
  logic last_grant;
`endif

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    grant_d  = 1'b0;
    grant_i  = 1'b0;
    req_next = '0;
    if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant_d = dreq_valid && (!ireq_valid || !last_grant);
`else
      grant_d = dreq_valid;
`endif
      grant_i = ireq_valid && !grant_d;
    end
    if (grant_d) begin
      req_next.write  = |dreq_strobe;
      req_next.addr   = ARB_ADDR_W'(dreq_addr);
      req_next.size   = dreq_size;
      req_next.strobe = dreq_strobe;
      req_next.data   = ARB_DATA_W'(dreq_data);
    end else if (grant_i) begin
      req_next.addr   = ARB_ADDR_W'(ireq_addr);
      req_next.size   = MSIZE_WORD;
    end
  end

  arb_req_latch u_req_latch (
    .clk   (clk),
    .reset (reset),
    .load  (grant_d || grant_i),
    .d     (req_next),
    .q     (req_q)
  );

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state <= BUSY_D;
          end else if (grant_i) begin
            state <= BUSY_I;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (grant_d || grant_i) begin
            last_grant <= grant_d;
          end
`endif
        end
        BUSY_I, BUSY_D: begin
          if (mresp_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completion is only forwarded if its master still wants it; otherwise dropped.
  assign complete = (state != IDLE) && mresp_ok && !reset;
  assign i_done   = complete && (state == BUSY_I) && ireq_valid;
  assign d_done   = complete && (state == BUSY_D) && dreq_valid;

  assign iresp_addr_ok = i_done;
  assign iresp_data_ok = i_done;
  assign iresp_data    = !i_done ? 32'd0 :
                         req_q.addr[2] ? mresp_data[63:32] : mresp_data[31:0];

  assign dresp_addr_ok = d_done;
  assign dresp_data_ok = d_done;
  assign dresp_data    = d_done ? mresp_data : '0;

  assign mreq_valid  = (state != IDLE) && !reset;
  assign mreq_write  = req_q.write;
  assign mreq_addr   = req_q.addr[ADDR_W-1:0];
  assign mreq_size   = req_q.size;
  assign mreq_strobe = req_q.strobe;
  assign mreq_data   = req_q.data[DATA_W-1:0];

endmodule
